// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result buffer each for the adder, multiplier and load unit,
// and one registered broadcast per cycle. Define CDB_RR_ARB_EN for round-robin arbitration.
module cdb_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_valid,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_data,
    input  logic              mul_valid,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    input  logic              ld_valid,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    output logic              add_ready,
    output logic              mul_ready,
    output logic              ld_ready,
    output logic [TAG_W-1:0]  cdb_id,
    output logic [DATA_W-1:0] cdb_data
);

    // Source index: 0 = add, 1 = mul, 2 = ld
    logic [2:0]        w_valid;
    logic [2:0]        w_ready;
    logic [2:0]        w_gnt;
    logic [2:0]        w_load;
    logic [TAG_W-1:0]  w_tag [3];
    logic [DATA_W-1:0] w_data [3];
    logic [TAG_W-1:0]  w_gnt_tag;
    logic [DATA_W-1:0] w_gnt_data;

    logic [2:0]        r_full;
    logic [TAG_W-1:0]  r_tag [3];
    logic [DATA_W-1:0] r_data [3];
    logic [TAG_W-1:0]  r_cdb_id;
    logic [DATA_W-1:0] r_cdb_data;

    assign w_valid   = {ld_valid, mul_valid, add_valid};
    assign w_tag[0]  = add_tag;
    assign w_tag[1]  = mul_tag;
    assign w_tag[2]  = ld_tag;
    assign w_data[0] = add_data;
    assign w_data[1] = mul_data;
    assign w_data[2] = ld_data;

    // A buffer being drained this cycle can take a new result on the same edge
    assign w_ready   = rst ? 3'b000 : (~r_full | w_gnt);
    assign add_ready = w_ready[0];
    assign mul_ready = w_ready[1];
    assign ld_ready  = w_ready[2];
    assign cdb_id    = r_cdb_id;
    assign cdb_data  = r_cdb_data;

    // Handshakes that carry a real tag load the buffer; tag 0 is accepted and dropped
    always_comb begin
        w_load = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_load[i] = w_valid[i] & w_ready[i] & (w_tag[i] != {TAG_W{1'b0}});
        end
    end

`ifdef CDB_RR_ARB_EN
    logic [1:0] r_last;

    function automatic logic [2:0] rr_pick(input logic [2:0] full, input logic [1:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            2'd0: begin
                if (full[1])      pick = 3'b010;
                else if (full[2]) pick = 3'b100;
                else if (full[0]) pick = 3'b001;
                else              pick = 3'b000;
            end
            2'd1: begin
                if (full[2])      pick = 3'b100;
                else if (full[0]) pick = 3'b001;
                else if (full[1]) pick = 3'b010;
                else              pick = 3'b000;
            end
            default: begin
                if (full[0])      pick = 3'b001;
                else if (full[1]) pick = 3'b010;
                else if (full[2]) pick = 3'b100;
                else              pick = 3'b000;
            end
        endcase
        return pick;
    endfunction

    // Round-robin grant starting after the last granted source
    always_comb begin
        w_gnt = rr_pick(r_full, r_last);
    end

    // Pointer resets to ld so that add is first in line; moves only on a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 2'd2;
        end else if (w_gnt[0]) begin
            r_last <= 2'd0;
        end else if (w_gnt[1]) begin
            r_last <= 2'd1;
        end else if (w_gnt[2]) begin
            r_last <= 2'd2;
        end else begin
            r_last <= r_last;
        end
    end
`else
    // Fixed priority ld > mul > add
    always_comb begin
        if (r_full[2])      w_gnt = 3'b100;
        else if (r_full[1]) w_gnt = 3'b010;
        else if (r_full[0]) w_gnt = 3'b001;
        else                w_gnt = 3'b000;
    end
`endif

    // One-hot grant mux of the buffered tag and data
    always_comb begin
        w_gnt_tag  = {TAG_W{1'b0}};
        w_gnt_data = {DATA_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            w_gnt_tag  = w_gnt_tag  | (r_tag[i]  & {TAG_W{w_gnt[i]}});
            w_gnt_data = w_gnt_data | (r_data[i] & {DATA_W{w_gnt[i]}});
        end
    end

    // Result buffers: reload wins over drain on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_tag[i]  <= {TAG_W{1'b0}};
                r_data[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_load[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= w_tag[i];
                    r_data[i] <= w_data[i];
                end else if (w_gnt[i]) begin
                    r_full[i] <= 1'b0;
                end else begin
                    r_full[i] <= r_full[i];
                end
            end
        end
    end

    // Registered broadcast, zero on idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_id   <= {TAG_W{1'b0}};
            r_cdb_data <= {DATA_W{1'b0}};
        end else if (|w_gnt) begin
            r_cdb_id   <= w_gnt_tag;
            r_cdb_data <= w_gnt_data;
        end else begin
            r_cdb_id   <= {TAG_W{1'b0}};
            r_cdb_data <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts with the edge they
// must appear after; a negedge monitor pops and compares tag, data and timing.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        add_valid, mul_valid, ld_valid;
    logic [3:0]  add_tag, mul_tag, ld_tag;
    logic [63:0] add_data, mul_data, ld_data;
    logic        add_ready, mul_ready, ld_ready;
    logic [3:0]  cdb_id;
    logic [63:0] cdb_data;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    cdb_arbiter #(.DATA_W(64), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_tag(add_tag), .add_data(add_data),
        .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
        .add_ready(add_ready), .mul_ready(mul_ready), .ld_ready(ld_ready),
        .cdb_id(cdb_id), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] tag, input logic [63:0] data, input int at);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        add_valid = 1'b0; mul_valid = 1'b0; ld_valid = 1'b0;
        add_tag = 4'd0; mul_tag = 4'd0; ld_tag = 4'd0;
        add_data = 64'd0; mul_data = 64'd0; ld_data = 64'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every non-zero CDB value must be the next expected broadcast at its cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cdb_id != 4'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bcast: got tag=%0d data=%0h expected none (cycle %0d)",
                             cdb_id, cdb_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cdb_id !== e.tag || cdb_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL bcast: got tag=%0d data=%0h cycle=%0d expected tag=%0d data=%0h cycle=%0d",
                                 cdb_id, cdb_data, cyc, e.tag, e.data, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (cdb_data !== 64'd0) begin
                    errors++;
                    $display("FAIL idle_data: got %0h expected 0 (cycle %0d)", cdb_data, cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_bcast: got tag=0 expected tag=%0d data=%0h at cycle %0d",
                             e.tag, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cdb_id", {60'd0, cdb_id}, 64'd0);
        check("rst_cdb_data", cdb_data, 64'd0);
        check("rst_readies", {61'd0, ld_ready, mul_ready, add_ready}, 64'd0);
        next_cycle();

        // Single add result right after reset release
        rst = 1'b0;
        add_valid = 1'b1; add_tag = 4'd1; add_data = 64'h11;
        push(4'd1, 64'h11, cyc + 2);
        @(negedge clk);
        check("first_add_ready", {63'd0, add_ready}, 64'd1);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        // All three sources at once
        add_valid = 1'b1; add_tag = 4'd2; add_data = 64'hA;
        mul_valid = 1'b1; mul_tag = 4'd4; mul_data = 64'hB;
        ld_valid  = 1'b1; ld_tag  = 4'd6; ld_data  = 64'hC;
`ifdef CDB_RR_ARB_EN
        push(4'd2, 64'hA, cyc + 2);
        push(4'd4, 64'hB, cyc + 3);
        push(4'd6, 64'hC, cyc + 4);
`else
        push(4'd6, 64'hC, cyc + 2);
        push(4'd4, 64'hB, cyc + 3);
        push(4'd2, 64'hA, cyc + 4);
`endif
        @(negedge clk);
        check("all_ready", {61'd0, ld_ready, mul_ready, add_ready}, 64'd7);
        next_cycle();
        idle_inputs();
        repeat (6) next_cycle();

        // Back-to-back mul results: accept while draining
        for (int i = 0; i < 4; i++) begin
            mul_valid = 1'b1;
            mul_tag   = (i % 2 == 0) ? 4'd4 : 4'd5;
            mul_data  = 64'h100 + 64'(i);
            push(mul_tag, mul_data, cyc + 2);
            @(negedge clk);
            check("mul_stream_ready", {63'd0, mul_ready}, 64'd1);
            next_cycle();
        end
        idle_inputs();
        repeat (4) next_cycle();

        // Boundary values: max tag, all-ones data
        mul_valid = 1'b1; mul_tag = 4'd15; mul_data = 64'hFFFF_FFFF_FFFF_FFFF;
        push(4'd15, 64'hFFFF_FFFF_FFFF_FFFF, cyc + 2);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        // Tag 0: handshake completes, nothing buffered or broadcast
        ld_valid = 1'b1; ld_tag = 4'd0; ld_data = 64'hFF;
        @(negedge clk);
        check("tag0_ready", {63'd0, ld_ready}, 64'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("tag0_not_buffered", {63'd0, ld_ready}, 64'd1);
        repeat (4) next_cycle();

        // Fill all buffers then reset before any grant
        add_valid = 1'b1; add_tag = 4'd3; add_data = 64'h33;
        mul_valid = 1'b1; mul_tag = 4'd5; mul_data = 64'h55;
        ld_valid  = 1'b1; ld_tag  = 4'd7; ld_data  = 64'h77;
        @(negedge clk);
        check("pre_rst_ready", {61'd0, ld_ready, mul_ready, add_ready}, 64'd7);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_readies", {61'd0, ld_ready, mul_ready, add_ready}, 64'd0);
        check("rst_mid_cdb_id", {60'd0, cdb_id}, 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {61'd0, ld_ready, mul_ready, add_ready}, 64'd7);
        check("post_rst_cdb_id", {60'd0, cdb_id}, 64'd0);
        repeat (6) next_cycle();

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) next_cycle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, the result/CDB data width.
REQ-002 The block SHALL have parameter TAG_W, default 4, the reservation-station tag width; tag 0 means notag.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have ports add_valid, mul_valid, ld_valid  input  1 each  a result is offered by the adder, multiplier or load unit.
REQ-006 The block SHALL have ports add_tag, mul_tag, ld_tag  input  TAG_W each  the producing reservation-station tag.
REQ-007 The block SHALL have ports add_data, mul_data, ld_data  input  DATA_W each  the result value.
REQ-008 The block SHALL have ports add_ready, mul_ready, ld_ready  output  1 each  the arbiter can accept that source's result this cycle.
REQ-009 The block SHALL have port cdb_id  output  TAG_W  the broadcast tag, 0 when idle.
REQ-010 The block SHALL have port cdb_data  output  DATA_W  the broadcast value, 0 when idle.

Function
REQ-011 The block SHALL hold one result buffer per source (full flag, tag, data).
REQ-012 A transfer SHALL occur on a rising edge when x_valid and x_ready are both 1; the buffer loads tag/data and sets full.
REQ-013 x_ready SHALL be combinational = buffer empty OR buffer granted this cycle (accept-while-drain, no bubble).
REQ-014 A transfer with tag 0 SHALL complete the handshake but SHALL NOT load the buffer or broadcast.
REQ-015 Each cycle, exactly one full buffer SHALL be granted if any is full; otherwise no grant.
REQ-016 On a granted edge, cdb_id/cdb_data SHALL register the granted buffer's tag/data, and that buffer SHALL clear unless simultaneously reloaded.
REQ-017 On an edge with no grant, cdb_id and cdb_data SHALL register 0.
REQ-018 Each broadcast SHALL be visible for exactly one cycle; a given result SHALL be broadcast exactly once.
REQ-019 Latency: handshake at edge E, buffer loaded at E; with no contention the result SHALL appear on CDB after edge E+1.
REQ-020 Outputs cdb_id and cdb_data SHALL be driven directly from flops (no combinational path from inputs).
REQ-021 Simultaneous offers from all three sources with empty buffers SHALL all be accepted in the same cycle.

Reset
REQ-022 While rst=1, all buffers SHALL be empty, cdb_id=0, cdb_data=0, the round-robin pointer SHALL be reset so add has highest priority.
REQ-023 Reset asserted mid-operation SHALL discard all buffered results with no broadcast; x_ready SHALL read 0 while rst=1.
REQ-024 After rst deasserts, the first handshake SHALL be possible on the next rising edge.

Configuration
REQ-025 Macro CDB_RR_ARB_EN defined: round-robin arbitration; priority order starts after the last granted source (add -> mul -> ld -> add); the pointer advances only on a grant.
REQ-026 With CDB_RR_ARB_EN defined, a full buffer SHALL be granted within 3 cycles of becoming full.
REQ-027 CDB_RR_ARB_EN undefined: fixed priority ld > mul > add; the lower-priority sources may starve.

Verification
REQ-028 Reset, then add_valid with tag 1, data 0x11 at edge 1 -> cdb_id=1, cdb_data=0x11 for exactly one cycle after edge 2, then 0/0.
REQ-029 add(tag 2,0xA), mul(tag 4,0xB), ld(tag 6,0xC) offered together, RR enabled -> broadcasts on three consecutive cycles in order 2,4,6; all readies 1 on the accept cycle.
REQ-030 Same stimulus, RR disabled -> broadcast order 6,4,2.
REQ-031 mul_valid held high with new tags 4,5,4,5 every cycle -> one broadcast per cycle and mul_ready never 0 (accept-while-drain).
REQ-032 ld_valid with tag 0, data 0xFF -> ld_ready 1, cdb_id stays 0 with no broadcast.
REQ-033 Load all three buffers, assert rst for 1 cycle before the first grant -> no broadcast occurs and cdb_id=0 throughout.
